vec_fetch_engine: RTL

Parametrised successor to the single-operand fetch engine. It accepts configuration and run commands over a valid/ready command port and holds W-base, X-base and length registers. On RUN it issues 2×LEN interleaved memory reads (W[i], X[i]), pairs the in-order responses, and streams {w, x} operand pairs to the compute datapath through a credit-limited pair FIFO. It sits between the GPU top-level command decoder and the memory port, and feeds the MAC array's source interface.

---
 rtl/vec_fetch_engine_pkg.sv | 15 +
 rtl/vec_fetch_engine_pair_fifo.sv | 52 +++++
 rtl/vec_fetch_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vec_fetch_engine_pkg.sv
// Shared opcodes and FSM state encoding for the vector operand fetch engine.
package vec_fetch_engine_pkg;

   localparam logic [1:0] OP_SET_W_BASE = 2'd0;
   localparam logic [1:0] OP_SET_X_BASE = 2'd1;
   localparam logic [1:0] OP_SET_LEN    = 2'd2;
   localparam logic [1:0] OP_RUN        = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/vec_fetch_engine_pair_fifo.sv
// Synchronous operand-pair FIFO; the read data comes straight from the storage
// register at the read pointer, so a push becomes visible the cycle after its edge.
module pair_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [AW-1:0]               wptr_q, rptr_q;
   logic [AW:0]                 cnt_q;
   logic                        do_pop;

   assign do_pop = pop && (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + AW'(1);
         case ({push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   assign rdata = mem_q[rptr_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/vec_fetch_engine.sv
// Vector operand fetch: issues interleaved W/X reads under a pair-credit limit,
// pairs the in-order responses and streams {w, x} through pair_fifo.
module vec_fetch_engine
   import vec_fetch_engine_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int LEN_WIDTH   = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_STRIDE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_vld,
   output logic                  cmd_rdy,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_data,
   output logic                  m_req_vld,
   input  logic                  m_req_rdy,
   output logic [ADDR_WIDTH-1:0] m_req_addr,
   input  logic                  m_rsp_vld,
   input  logic [DATA_WIDTH-1:0] m_rsp_data,
   output logic                  src_vld,
   input  logic                  src_rdy,
   output logic [DATA_WIDTH-1:0] src_w_data,
   output logic [DATA_WIDTH-1:0] src_x_data,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] w_base_q, w_base_d, x_base_q, x_base_d;
   logic [ADDR_WIDTH-1:0] off_q, off_d, addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, elem_q, elem_d;
   logic [CW-1:0]         pif_q, pif_d;
   logic [DATA_WIDTH-1:0] w_hold_q, w_hold_d;
   logic                  req_vld_q, req_vld_d, phase_q, phase_d;
   logic                  par_q, par_d, done_q, done_d;

   logic [CW-1:0]               fifo_cnt;
   logic                        fifo_empty, fifo_full;
   logic [2*DATA_WIDTH-1:0]     fifo_rdata;
   logic cmd_acc, req_acc, w_acc, rsp_take, push, pop, credit_ok;

   assign cmd_rdy  = (state_q == IDLE);
   assign cmd_acc  = cmd_vld && cmd_rdy;
   assign req_acc  = req_vld_q && m_req_rdy;
   assign w_acc    = req_acc && !phase_q;
   assign rsp_take = m_rsp_vld && (state_q != IDLE);
   assign push     = rsp_take && par_q && !fifo_full;
   assign pop      = src_vld && src_rdy;
   // Every W in flight owns a FIFO slot until its pair is popped.
   assign credit_ok = ({1'b0, pif_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);

   pair_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({w_hold_q, m_rsp_data}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         w_base_q  <= '0;
         x_base_q  <= '0;
         len_q     <= '0;
         elem_q    <= '0;
         off_q     <= '0;
         addr_q    <= '0;
         pif_q     <= '0;
         w_hold_q  <= '0;
         req_vld_q <= 1'b0;
         phase_q   <= 1'b0;
         par_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         w_base_q  <= w_base_d;
         x_base_q  <= x_base_d;
         len_q     <= len_d;
         elem_q    <= elem_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         pif_q     <= pif_d;
         w_hold_q  <= w_hold_d;
         req_vld_q <= req_vld_d;
         phase_q   <= phase_d;
         par_q     <= par_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      w_base_d  = w_base_q;
      x_base_d  = x_base_q;
      len_d     = len_q;
      elem_d    = elem_q;
      off_d     = off_q;
      addr_d    = addr_q;
      pif_d     = pif_q;
      w_hold_d  = w_hold_q;
      req_vld_d = req_vld_q;
      phase_d   = phase_q;
      par_d     = par_q;
      done_d    = 1'b0;

      if (cmd_acc) begin
         case (cmd_op)
            OP_SET_W_BASE: w_base_d = cmd_data;
            OP_SET_X_BASE: x_base_d = cmd_data;
            OP_SET_LEN:    len_d    = cmd_data[LEN_WIDTH-1:0];
            OP_RUN: begin
               if (len_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = ISSUE;
                  elem_d    = '0;
                  off_d     = '0;
                  phase_d   = 1'b0;
                  par_d     = 1'b0;
                  req_vld_d = 1'b1;
                  addr_d    = w_base_q;
               end
            end
            default: ;
         endcase
      end

      if (state_q == ISSUE) begin
         if (w_acc) begin
            // X follows its W unconditionally; the W already took the credit.
            phase_d = 1'b1;
            addr_d  = x_base_q + off_q;
         end else if (req_acc) begin
            if (elem_q == len_q - LEN_WIDTH'(1)) begin
               req_vld_d = 1'b0;
               state_d   = DRAIN;
            end else begin
               elem_d    = elem_q + LEN_WIDTH'(1);
               off_d     = off_q + STRIDE;
               phase_d   = 1'b0;
               req_vld_d = credit_ok;
               addr_d    = w_base_q + off_q + STRIDE;
            end
         end else if (!req_vld_q && credit_ok) begin
            req_vld_d = 1'b1;
            addr_d    = w_base_q + off_q;
         end
      end

      case ({w_acc, push})
         2'b10:   pif_d = pif_q + CW'(1);
         2'b01:   pif_d = pif_q - CW'(1);
         default: ;
      endcase

      if (rsp_take) begin
         par_d = !par_q;
         if (!par_q) w_hold_d = m_rsp_data;
      end

      // Leave DRAIN on the edge that pops the last pair so done lands in the first IDLE cycle.
      if (state_q == DRAIN && pif_q == '0 &&
          (fifo_empty || (fifo_cnt == CW'(1) && pop))) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end
   end

   assign m_req_vld  = req_vld_q;
   assign m_req_addr = addr_q;
   assign src_vld    = !fifo_empty;
   assign src_w_data = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign src_x_data = fifo_rdata[DATA_WIDTH-1:0];
   assign busy       = (state_q != IDLE);
   assign done       = done_q;

endmodule
